// File: rtl/apb_cmd_master.sv
// apb_cmd_master: converts a valid/ready command stream into APB setup/access transfers.
// Optional macro APB_MASTER_PREADY_EN adds a PREADY input that stretches ACCESS with wait states.
module apb_cmd_master #(
    parameter int unsigned AMBA_WORD       = 16,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned CMD_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
`ifdef APB_MASTER_PREADY_EN
    input  logic                       PREADY,
`endif
    input  logic [AMBA_WORD-1:0]       PRDATA
);
    localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned EntW = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                     state_q, state_d;
    logic [EntW-1:0]            fifo_q [CMD_DEPTH];
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            count_q;
    logic                       psel_q, penable_q, pwrite_q;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
    logic [AMBA_WORD-1:0]       pwdata_q;
    logic                       rsp_valid_q, rsp_write_q;
    logic [AMBA_WORD-1:0]       rsp_rdata_q;

    logic                       push, pop, complete, slave_ready;
    logic                       head_write;
    logic [AMBA_ADDR_WIDTH-1:0] head_addr;
    logic [AMBA_WORD-1:0]       head_wdata;

`ifdef APB_MASTER_PREADY_EN
    assign slave_ready = PREADY;
`else
    assign slave_ready = 1'b1;
`endif

    // No full-bypass: a pop this cycle does not free a slot for a push this cycle.
    assign cmd_ready = (count_q != CntW'(CMD_DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign complete  = (state_q == StAccess) & slave_ready;
    assign busy      = (count_q != '0) | (state_q != StIdle);
    assign {head_write, head_addr, head_wdata} = fifo_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (complete) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= (state_d != StIdle);
            penable_q <= (state_d == StAccess);
            if (pop) begin
                pwrite_q <= head_write;
                paddr_q  <= head_addr;
                pwdata_q <= head_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= complete;
            if (complete) begin
                rsp_write_q <= pwrite_q;
                rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            end
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based transaction model.
module tb_apb_cmd_master;
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready;

    int vectors = 0;
    int errors  = 0;
    int rsp_cnt = 0;
    int acc_cnt = 0;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;
    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
    } rsp_t;
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    cmd_t exp_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    apb_cmd_master #(
        .AMBA_WORD      (DW),
        .AMBA_ADDR_WIDTH(AW),
        .CMD_DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .PADDR    (paddr),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PWRITE   (pwrite),
        .PWDATA   (pwdata),
`ifdef APB_MASTER_PREADY_EN
        .PREADY   (pready),
`endif
        .PRDATA   (prdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: commands complete in acceptance order; a read returns PRDATA seen at
    // its completing ACCESS edge, a write returns 0; response appears the cycle after completion.
    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (rst !== 1'b0) begin
            exp_q.delete();
            rsp_q.delete();
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            if (penable) chk("penable_without_psel", psel, 1);
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_write", rsp_write, r.write);
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                end
            end else if (rsp_q.size() != 0) begin
                chk("rsp_missing", rsp_valid, 1);
                rsp_q.delete();
            end
            if (psel && penable && pready) begin
                if (exp_q.size() == 0) begin
                    chk("transfer_unexpected", penable, 0);
                end else begin
                    c = exp_q.pop_front();
                    chk("paddr", paddr, c.addr);
                    chk("pwrite", pwrite, c.write);
                    chk("pwdata", pwdata, c.wdata);
                    r.write = c.write;
                    r.rdata = c.write ? '0 : prdata;
                    rsp_q.push_back(r);
                end
            end
            if (cmd_valid && cmd_ready) begin
                c.write = cmd_write;
                c.addr  = cmd_addr;
                c.wdata = cmd_wdata;
                exp_q.push_back(c);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic run_single(input vec_t v);
        step();
        drive(v.write, v.addr, v.wdata);
        prdata = v.prdata;
        step();
        cmd_valid = 1'b0;
        chk("single_idle_after_accept", {psel, busy}, 2'b01);
        step();
        chk("single_setup", {psel, penable}, 2'b10);
        step();
        chk("single_access", {psel, penable, pwrite}, {2'b11, v.write});
        chk("single_paddr", paddr, v.addr);
        chk("single_pwdata", pwdata, v.wdata);
        chk("single_no_early_rsp", rsp_valid, 0);
        step();
        chk("single_rsp", {rsp_valid, rsp_write, psel}, {1'b1, v.write, 1'b0});
        chk("single_rsp_rdata", rsp_rdata, v.exp_rdata);
        step();
        chk("single_back_idle", {rsp_valid, busy, psel}, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        cmd_t b[4];
        int   psel_run, max_run, pulses, last, gap_bad, a0, r0, sent, saw_low, cyc;
        logic rdy;

        tbl[0] = '{1'b1, 20'h0000C, 16'h0020, 16'h1234, 16'h0000};
        tbl[1] = '{1'b1, 20'h00008, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[2] = '{1'b0, 20'h00004, 16'h5555, 16'h00AE, 16'h00AE};
        tbl[3] = '{1'b0, 20'h00003, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[4] = '{1'b1, 20'hFFFFF, 16'hFFFF, 16'hA5A5, 16'h0000};
        tbl[5] = '{1'b0, 20'h80001, 16'h1111, 16'h0000, 16'h0000};

        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        prdata = '0; pready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("reset_bus", {psel, penable, pwrite}, 3'b000);
        chk("reset_ready_busy", {cmd_ready, busy, rsp_valid}, 3'b100);
        chk("reset_paddr", paddr, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_single(tbl[i]);

        // Back-to-back burst of four writes: bus stays selected for 8 cycles.
        b[0] = '{1'b1, 20'hC, 16'h0020};
        b[1] = '{1'b1, 20'h8, 16'h0000};
        b[2] = '{1'b1, 20'h4, 16'h00AE};
        b[3] = '{1'b1, 20'h0, 16'h0001};
        psel_run = 0; max_run = 0; pulses = 0; last = -1; gap_bad = 0; a0 = acc_cnt;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i < 4) drive(b[i].write, b[i].addr, b[i].wdata);
            else cmd_valid = 1'b0;
            if (psel) begin
                psel_run++;
                if (psel_run > max_run) max_run = psel_run;
            end else begin
                psel_run = 0;
            end
            if (rsp_valid) begin
                if (last >= 0 && i - last != 2) gap_bad++;
                last = i;
                pulses++;
            end
        end
        chk("burst_accepted", acc_cnt - a0, 4);
        chk("burst_psel_run", max_run, 8);
        chk("burst_rsp_pulses", pulses, 4);
        chk("burst_rsp_spacing", gap_bad, 0);

        // Offer 9 commands as fast as accepted: FIFO must fill and back-pressure.
        a0 = acc_cnt; r0 = rsp_cnt; sent = 0; saw_low = 0; cyc = 0;
        prdata = 16'hC0DE;
        step();
        drive(1'b0, 20'h10, 16'h0000);
        while (sent < 9 && cyc < 100) begin
            rdy = cmd_ready;
            step();
            cyc++;
            if (rdy) begin
                sent++;
                if (sent < 9) drive(sent[0], AW'(32'h10 + sent), DW'(32'h0101 * sent));
                else cmd_valid = 1'b0;
            end else begin
                saw_low++;
            end
        end
        cmd_valid = 1'b0;
        cyc = 0;
        while (rsp_cnt - r0 < 9 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("fill_saw_not_ready", saw_low > 0, 1);
        chk("fill_accepted", acc_cnt - a0, 9);
        chk("fill_responses", rsp_cnt - r0, 9);

        // Reset during ACCESS of the second of three queued writes.
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b1, AW'(32'h20 + 4 * i), DW'(32'h7000 + i));
        end
        step();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(psel && penable && paddr == 20'h24) && cyc < 20) begin
            step();
            cyc++;
        end
        chk("rst_found_second_access", {psel, penable, paddr}, {2'b11, 20'h24});
        r0 = rsp_cnt;
        #1 rst = 1'b1;
        #1;
        chk("rst_async_bus", {psel, penable}, 2'b00);
        chk("rst_async_ready_busy", {cmd_ready, busy}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_no_rsp", rsp_valid, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_after_idle", {psel, busy, rsp_valid}, 3'b000);
        end
        chk("rst_no_rsp_count", rsp_cnt - r0, 0);

`ifdef APB_MASTER_PREADY_EN
        // PREADY low for three cycles stretches ACCESS to four cycles.
        step();
        drive(1'b0, 20'h4, 16'h0000);
        prdata = 16'h00AE;
        step();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!penable && cyc < 10) begin
            step();
            cyc++;
        end
        pready = 1'b0;
        psel_run = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (penable) psel_run++;
        end
        pready = 1'b1;
        step();
        chk("wait_access_len", psel_run, 4);
        chk("wait_done", {penable, rsp_valid, rsp_write}, 3'b010);
        chk("wait_rdata", rsp_rdata, 16'h00AE);
`endif

        // Randomized traffic against the transaction model.
        for (int i = 0; i < 600; i++) begin
            step();
            cmd_valid = ($urandom_range(0, 99) < 55);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            prdata    = DW'($urandom);
`ifdef APB_MASTER_PREADY_EN
            pready    = ($urandom_range(0, 3) != 0);
`endif
        end
        cmd_valid = 1'b0;
        pready    = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            step();
            cyc++;
        end
        step();
        step();
        chk("drain_idle", {busy, psel}, 2'b00);
        chk("drain_model_empty", exp_q.size() + rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
